// File: rtl/lc3_mem_access_seq.sv
// LC3 MemAccess stage: sequences LD/ST/LDI/STI over a request/complete handshake.
// Optional per-access timeout enabled by defining MEM_TIMEOUT_EN.
module lc3_mem_access_seq #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_start,
    input  logic [1:0]        mem_op,
    input  logic [ADDR_W-1:0] pcout,
    input  logic [DATA_W-1:0] M_Data,
    input  logic [DATA_W-1:0] Data_dout,
    input  logic              complete_data,
    output logic [ADDR_W-1:0] Data_addr,
    output logic [DATA_W-1:0] Data_din,
    output logic              Data_rd,
    output logic              Data_en,
    output logic [DATA_W-1:0] memout,
    output logic [1:0]        mem_state,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        S_RD   = 2'b00,
        S_IND  = 2'b01,
        S_WR   = 2'b10,
        S_IDLE = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic              store_q, store_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] memout_q, memout_d;
    logic              req_first_q, req_first_d;
    logic              done_q, done_d;
    logic              err_d;
    logic              in_access;

    assign in_access = (state_q != S_IDLE);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;
`endif

    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        addr_d      = addr_q;
        din_d       = din_q;
        memout_d    = memout_q;
        req_first_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (mem_start) begin
                    addr_d      = pcout;
                    din_d       = M_Data;
                    store_d     = mem_op[0];
                    req_first_d = 1'b1;
                    if (mem_op[1])
                        state_d = S_IND;
                    else if (mem_op[0])
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_IND: begin
                if (complete_data) begin
                    // Pointer fetched; the second access reuses the address register.
                    addr_d      = ADDR_W'(Data_dout);
                    req_first_d = 1'b1;
                    state_d     = store_q ? S_WR : S_RD;
                end
            end
            S_RD: begin
                if (complete_data) begin
                    memout_d = Data_dout;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_WR: begin
                if (complete_data) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef MEM_TIMEOUT_EN
        cnt_d = cnt_q;
        if (req_first_d)
            cnt_d = '0;
        else if (in_access)
            cnt_d = cnt_q + 1'b1;

        // A completion landing on the limit cycle takes priority.
        if (in_access && !complete_data && cnt_q == LIMIT) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            store_q     <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            memout_q    <= '0;
            req_first_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            memout_q    <= memout_d;
            req_first_q <= req_first_d;
            done_q      <= done_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign mem_err = err_q;
`else
    assign mem_err = err_d;
`endif

    assign Data_addr = addr_q;
    assign Data_din  = din_q;
    assign Data_rd   = (state_q != S_WR);
    assign Data_en   = in_access && req_first_q;
    assign memout    = memout_q;
    assign mem_state = state_q;
    assign mem_busy  = in_access;
    assign mem_done  = done_q;

endmodule

// File: tb/tb_lc3_mem_access_seq.sv
// Directed bench for lc3_mem_access_seq with a transaction-level model and memory responder.
// Timeout scenarios switch on MEM_TIMEOUT_EN.
module tb_lc3_mem_access_seq;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_start;
    logic [1:0]  mem_op;
    logic [15:0] pcout;
    logic [15:0] M_Data;
    logic [15:0] Data_dout;
    logic        complete_data;
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic        Data_rd;
    logic        Data_en;
    logic [15:0] memout;
    logic [1:0]  mem_state;
    logic        mem_busy;
    logic        mem_done;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    lc3_mem_access_seq #(
        .ADDR_W(16),
        .DATA_W(16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_start(mem_start),
        .mem_op(mem_op),
        .pcout(pcout),
        .M_Data(M_Data),
        .Data_dout(Data_dout),
        .complete_data(complete_data),
        .Data_addr(Data_addr),
        .Data_din(Data_din),
        .Data_rd(Data_rd),
        .Data_en(Data_en),
        .memout(memout),
        .mem_state(mem_state),
        .mem_busy(mem_busy),
        .mem_done(mem_done),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Data memory responder: completes wait_cyc cycles after each request.
    logic [15:0] mem [logic [15:0]];
    int          wait_cyc = 0;
    bit          resp_en  = 1'b1;
    bit          flush    = 1'b0;
    bit          pend     = 1'b0;
    int          rem      = 0;
    bit          c_wr     = 1'b0;
    logic [15:0] c_addr   = '0;
    logic [15:0] c_din    = '0;

    initial begin
        complete_data = 1'b0;
        Data_dout     = 16'hDEAD;
    end

    always @(posedge clk) begin
        if (complete_data) begin
            if (c_wr)
                mem[c_addr] = c_din;
            pend = 1'b0;
        end else if (pend && rem > 0) begin
            rem--;
        end
        if (flush)
            pend = 1'b0;
        #1;
        if (Data_en) begin
            pend = 1'b1;
            rem  = wait_cyc;
        end
        complete_data = pend && rem == 0 && resp_en;
        if (complete_data) begin
            c_wr   = !Data_rd;
            c_addr = Data_addr;
            c_din  = Data_din;
            if (c_wr)
                Data_dout = 16'h0000;
            else if (mem.exists(c_addr))
                Data_dout = mem[c_addr];
            else
                Data_dout = 16'h0000;
        end else begin
            Data_dout = 16'hDEAD;
        end
    end

    // Transaction model: an op is a list of one or two accesses.
    bit          m_busy   = 1'b0;
    int          m_steps  = 0;
    bit          m_store  = 1'b0;
    bit          m_cur_wr = 1'b0;
    bit          m_first  = 1'b0;
    logic [15:0] m_addr   = '0;
    logic [15:0] m_din    = '0;
    logic [15:0] m_memout = '0;
    bit          m_done   = 1'b0;
    bit          m_err    = 1'b0;
    int          m_wait   = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_busy   = 1'b0;
            m_steps  = 0;
            m_store  = 1'b0;
            m_cur_wr = 1'b0;
            m_first  = 1'b0;
            m_addr   = '0;
            m_din    = '0;
            m_memout = '0;
            m_done   = 1'b0;
            m_err    = 1'b0;
            m_wait   = 0;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (!m_busy) begin
                if (mem_start) begin
                    m_busy   = 1'b1;
                    m_addr   = pcout;
                    m_din    = M_Data;
                    m_store  = mem_op[0];
                    m_steps  = mem_op[1] ? 2 : 1;
                    m_cur_wr = (m_steps == 1) && m_store;
                    m_first  = 1'b1;
                    m_wait   = 0;
                end
            end else if (complete_data) begin
                if (m_steps == 2) begin
                    m_addr   = Data_dout;
                    m_steps  = 1;
                    m_cur_wr = m_store;
                    m_first  = 1'b1;
                    m_wait   = 0;
                end else begin
                    if (!m_cur_wr)
                        m_memout = Data_dout;
                    m_busy  = 1'b0;
                    m_done  = 1'b1;
                    m_first = 1'b0;
                end
            end else begin
                m_first = 1'b0;
                m_wait++;
`ifdef MEM_TIMEOUT_EN
                if (m_wait == TO) begin
                    m_err  = 1'b1;
                    m_busy = 1'b0;
                end
`endif
            end
        end
    end

    bit chk_on = 1'b0;

    always @(negedge clk) begin
        if (chk_on) begin
            logic [1:0] es;
            if (!m_busy)
                es = 2'b11;
            else if (m_steps == 2)
                es = 2'b01;
            else
                es = m_cur_wr ? 2'b10 : 2'b00;
            chk("m_state", 32'(mem_state), 32'(es));
            chk("m_busy", 32'(mem_busy), 32'(m_busy));
            chk("m_en", 32'(Data_en), 32'(m_busy && m_first));
            chk("m_rd", 32'(Data_rd), 32'(!(m_busy && m_cur_wr)));
            chk("m_memout", 32'(memout), 32'(m_memout));
            chk("m_done", 32'(mem_done), 32'(m_done));
            chk("m_err", 32'(mem_err), 32'(m_err));
            if (m_busy) begin
                chk("m_addr", 32'(Data_addr), 32'(m_addr));
                chk("m_din", 32'(Data_din), 32'(m_din));
            end
        end
    end

    task automatic nck();
        @(negedge clk);
    endtask

    task automatic start(input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] d);
        mem_op    = op;
        pcout     = a;
        M_Data    = d;
        mem_start = 1'b1;
    endtask

    initial begin
        int ind_c;
        int rd_c;
        int wr_c;
        int done_c;
        int err_c;

        mem[16'h3000] = 16'hABCD;
        mem[16'h4000] = 16'h5000;
        mem[16'h6000] = 16'h7000;
        mem[16'h7000] = 16'hBEEF;

        reset     = 1'b0;
        mem_start = 1'b0;
        mem_op    = 2'b00;
        pcout     = 16'h0000;
        M_Data    = 16'h0000;

        // Reset for two edges
        nck();
        nck();
        chk("rst_state", 32'(mem_state), 32'h3);
        chk("rst_memout", 32'(memout), 32'h0);
        chk("rst_en", 32'(Data_en), 32'h0);
        chk("rst_busy", 32'(mem_busy), 32'h0);
        chk("rst_rd", 32'(Data_rd), 32'h1);
        chk("rst_addr", 32'(Data_addr), 32'h0);
        chk("rst_din", 32'(Data_din), 32'h0);
        chk("rst_done", 32'(mem_done), 32'h0);
        chk("rst_err", 32'(mem_err), 32'h0);
        reset  = 1'b1;
        chk_on = 1'b1;

        // LD zero-wait
        nck();
        start(2'b00, 16'h3000, 16'h0000);
        nck();
        mem_start = 1'b0;
        chk("ld_en", 32'(Data_en), 32'h1);
        chk("ld_rd", 32'(Data_rd), 32'h1);
        chk("ld_addr", 32'(Data_addr), 32'h3000);
        chk("ld_done_early", 32'(mem_done), 32'h0);
        nck();
        chk("ld_memout", 32'(memout), 32'hABCD);
        chk("ld_done", 32'(mem_done), 32'h1);
        chk("ld_idle", 32'(mem_state), 32'h3);

        // STI issued back-to-back in the done cycle
        start(2'b11, 16'h4000, 16'h1234);
        nck();
        mem_start = 1'b0;
        chk("sti_en1", 32'(Data_en), 32'h1);
        chk("sti_addr1", 32'(Data_addr), 32'h4000);
        chk("sti_rd1", 32'(Data_rd), 32'h1);
        chk("sti_state1", 32'(mem_state), 32'h1);
        nck();
        chk("sti_en2", 32'(Data_en), 32'h1);
        chk("sti_addr2", 32'(Data_addr), 32'h5000);
        chk("sti_din2", 32'(Data_din), 32'h1234);
        chk("sti_rd2", 32'(Data_rd), 32'h0);
        chk("sti_state2", 32'(mem_state), 32'h2);
        nck();
        chk("sti_done", 32'(mem_done), 32'h1);
        chk("sti_memout", 32'(memout), 32'hABCD);
        start(2'b00, 16'h5000, 16'h0000);
        nck();
        mem_start = 1'b0;
        chk("rb_en", 32'(Data_en), 32'h1);
        chk("rb_addr", 32'(Data_addr), 32'h5000);
        nck();
        chk("rb_memout", 32'(memout), 32'h1234);
        chk("rb_done", 32'(mem_done), 32'h1);

        // LDI, 3-cycle waits, stray start mid-op
        wait_cyc = 3;
        nck();
        start(2'b10, 16'h6000, 16'h0000);
        ind_c  = 0;
        rd_c   = 0;
        wr_c   = 0;
        done_c = 0;
        for (int i = 0; i < 14; i++) begin
            nck();
            if (i == 3)
                start(2'b01, 16'h1111, 16'h9999);
            else
                mem_start = 1'b0;
            if (mem_state == 2'b01) ind_c++;
            if (mem_state == 2'b00) rd_c++;
            if (mem_state == 2'b10) wr_c++;
            if (mem_done) done_c++;
        end
        chk("ldi_ind_cycles", 32'(ind_c), 32'd4);
        chk("ldi_rd_cycles", 32'(rd_c), 32'd4);
        chk("ldi_wr_cycles", 32'(wr_c), 32'd0);
        chk("ldi_done_cnt", 32'(done_c), 32'd1);
        chk("ldi_memout", 32'(memout), 32'hBEEF);

        // Reset during the WR wait; late completion must be ignored
        start(2'b01, 16'h2000, 16'h5555);
        nck();
        mem_start = 1'b0;
        chk("wrst_en", 32'(Data_en), 32'h1);
        chk("wrst_state", 32'(mem_state), 32'h2);
        nck();
        reset = 1'b0;
        nck();
        chk("wrst_idle", 32'(mem_state), 32'h3);
        chk("wrst_en0", 32'(Data_en), 32'h0);
        chk("wrst_busy", 32'(mem_busy), 32'h0);
        chk("wrst_memout", 32'(memout), 32'h0);
        reset = 1'b1;
        nck();
        chk("late_state", 32'(mem_state), 32'h3);
        chk("late_done", 32'(mem_done), 32'h0);
        nck();
        chk("late_state2", 32'(mem_state), 32'h3);
        chk("late_done2", 32'(mem_done), 32'h0);
        chk("late_en", 32'(Data_en), 32'h0);

        // Completion exactly on the timeout limit cycle
        wait_cyc = TO - 1;
        start(2'b00, 16'h3000, 16'h0000);
        done_c = 0;
        err_c  = 0;
        for (int k = 0; k < TO + 3; k++) begin
            nck();
            mem_start = 1'b0;
            if (mem_done) done_c++;
            if (mem_err) err_c++;
        end
        chk("lim_done_cnt", 32'(done_c), 32'd1);
        chk("lim_err_cnt", 32'(err_c), 32'd0);
        chk("lim_memout", 32'(memout), 32'hABCD);

        // No completion at all
        wait_cyc = 0;
        resp_en  = 1'b0;
        start(2'b00, 16'h3000, 16'h0000);
        nck();
        mem_start = 1'b0;
        chk("to_en", 32'(Data_en), 32'h1);
`ifdef MEM_TIMEOUT_EN
        for (int k = 1; k <= TO + 1; k++) begin
            nck();
            if (k == TO - 1) begin
                chk("to_err_early", 32'(mem_err), 32'h0);
                chk("to_busy", 32'(mem_busy), 32'h1);
            end
            if (k == TO) begin
                chk("to_err", 32'(mem_err), 32'h1);
                chk("to_idle", 32'(mem_state), 32'h3);
                chk("to_done", 32'(mem_done), 32'h0);
                chk("to_memout", 32'(memout), 32'hABCD);
            end
            if (k == TO + 1)
                chk("to_err_pulse", 32'(mem_err), 32'h0);
        end
        flush = 1'b1;
        nck();
        flush   = 1'b0;
        resp_en = 1'b1;
`else
        for (int k = 1; k <= 12; k++) begin
            nck();
            if (k == 12) begin
                chk("nto_busy", 32'(mem_busy), 32'h1);
                chk("nto_err", 32'(mem_err), 32'h0);
            end
        end
        resp_en = 1'b1;
        nck();
        nck();
        chk("nto_done", 32'(mem_done), 32'h1);
        chk("nto_memout", 32'(memout), 32'hABCD);
`endif
        nck();
        nck();
        chk("end_idle", 32'(mem_state), 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
